uart_tx_fifo: RTL

Parametrised successor to the UART transmitter, with configurable data width, parity mode, stop-bit count and baud divisor. A small transmit FIFO lets software or an upstream block queue several words, so frames go out back-to-back with no idle gap. The block sits between the host-side register/stream logic and the serial TX pin, and serialises LSB-first standard asynchronous frames.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter with a transmit FIFO.
package uart_pkg;

    // Parity modes, encoded to match the PARITY parameter values.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Transmit FSM states; PARITY is skipped when parity is disabled.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int baud_div(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO. A push while full and a pop while empty are ignored.
// The head word is always visible on rdata.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance pointers and occupancy; a simultaneous push and pop keeps the level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by the active-low async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a small FIFO. Frames are sent LSB
// first; a word waiting at the end of the last stop bit starts the next
// frame immediately with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 1_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_drop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          tx_out
);

    localparam int BAUD_DIV = baud_div(CLK_RATE, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W    = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != int'(PAR_NONE));
    localparam bit               ODD_PARITY = (PARITY == int'(PAR_ODD));

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_RATE/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_out_q, tx_out_d;
    logic                 drop_q, drop_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_end  = (cnt_q == CNT_LAST);
    assign tx_ready = !fifo_full;
    assign tx_drop  = drop_q;
    assign tx_busy  = (state_q != IDLE) || !fifo_empty;
    assign tx_out   = tx_out_q;

    // Next-state logic: sequences start, data, optional parity and stop bits,
    // popping the FIFO head whenever a new frame begins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_out_d = tx_out_q;
        fifo_pop = 1'b0;
        drop_d   = tx_valid && fifo_full;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    par_d    = ODD_PARITY ? ~(^fifo_rdata) : ^fifo_rdata;
                    tx_out_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PARITY) begin
                            tx_out_d = par_q;
                            state_d  = uart_pkg::PARITY;
                        end else begin
                            tx_out_d = 1'b1;
                            state_d  = STOP;
                        end
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        tx_out_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            uart_pkg::PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    tx_out_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            par_d    = ODD_PARITY ? ~(^fifo_rdata) : ^fifo_rdata;
                            tx_out_d = 1'b0;
                            state_d  = START;
                        end else begin
                            tx_out_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_out_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered line/drop outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
            drop_q   <= drop_d;
        end
    end

endmodule
